// File: rtl/case6_pipe_eval.sv
// case6_pipe_eval: pipelined, parametrised case6 evaluator with a y3 hit counter.
// Latency 2 cycles from input handshake to out_valid; throughput 1 result/cycle.
// Backpressure: out_ready low stalls s2, then s1, and in_ready drops once both are full.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready depends only on state and out_ready
//   and_grp/or_grp/par_grp  reduction operands (AND, OR, XOR)
//   par_inv             parity invert, present only when CASE6_PAR_INV_EN is defined
//   out_valid/out_ready result handshake carrying y1/y2/y3
//   hit_clr             synchronous clear of hit_cnt (wins over a simultaneous hit)
//   hit_cnt             saturating count of delivered results with y3=1
// Optional feature macro: CASE6_PAR_INV_EN
module case6_pipe_eval #(
  parameter int AW = 2,
  parameter int OW = 2,
  parameter int PW = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] and_grp,
  input  logic [OW-1:0] or_grp,
  input  logic [PW-1:0] par_grp,
`ifdef CASE6_PAR_INV_EN
  input  logic          par_inv,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic          y1,
  output logic          y2,
  output logic          y3,
  input  logic          hit_clr,
  output logic [CW-1:0] hit_cnt
);

  // Stage 1 holds the three reduced operand bits.
  logic s1_valid;
  logic s1_p;
  logic s1_a;
  logic s1_o;

  // Stage 2 holds the evaluated result.
  logic s2_valid;

  logic s1_adv;
  logic s2_adv;
  logic in_fire;
  logic out_fire;

  // Effective parity of the incoming operand. With the invert feature the
  // inversion is folded in before registering, so s1 carries the final p.
  logic p_in;
`ifdef CASE6_PAR_INV_EN
  assign p_in = (^par_grp) ^ par_inv;
`else
  assign p_in = ^par_grp;
`endif

  // Result equations evaluated from stage-1 values.
  logic y1_nxt;
  logic y2_nxt;
  logic y3_nxt;

  always_comb begin
    y2_nxt = ~s1_a | s1_p;
    y3_nxt = s1_p & ~s1_o;
    y1_nxt = (~s1_p | s1_o) & y2_nxt;
  end

  // A stage may load when it is empty or its content is leaving this cycle.
  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = s2_valid & out_ready;

  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= 1'b0;
      s1_a     <= 1'b0;
      s1_o     <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_p <= p_in;
        s1_a <= &and_grp;
        s1_o <= |or_grp;
      end
    end
  end

  // Results are only overwritten by a valid stage-1 entry, so y1..y3 keep
  // their last values while s2 is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      y1       <= 1'b0;
      y2       <= 1'b0;
      y3       <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y1 <= y1_nxt;
        y2 <= y2_nxt;
        y3 <= y3_nxt;
      end
    end
  end

  // Hits are counted when the result is actually taken by the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if (hit_clr) begin
      hit_cnt <= '0;
    end else if (out_fire && y3 && (hit_cnt != {CW{1'b1}})) begin
      hit_cnt <= hit_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_case6_pipe_eval.sv
module tb_case6_pipe_eval;
  localparam int AW = 2;
  localparam int OW = 2;
  localparam int PW = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] and_grp;
  logic [OW-1:0] or_grp;
  logic [PW-1:0] par_grp;
  logic          par_inv;
  logic          out_valid;
  logic          out_ready;
  logic          y1, y2, y3;
  logic          hit_clr;
  logic [CW-1:0] hit_cnt;

  case6_pipe_eval #(.AW(AW), .OW(OW), .PW(PW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .and_grp(and_grp), .or_grp(or_grp), .par_grp(par_grp),
`ifdef CASE6_PAR_INV_EN
    .par_inv(par_inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .y1(y1), .y2(y2), .y3(y3),
    .hit_clr(hit_clr), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic pi_eff;
`ifdef CASE6_PAR_INV_EN
  assign pi_eff = par_inv;
`else
  assign pi_eff = 1'b0;
`endif

  // Returns {y1,y2,y3} from the reduction rules.
  function automatic logic [2:0] ref_y(input logic [AW-1:0] a, input logic [OW-1:0] o,
                                       input logic [PW-1:0] pg, input logic pi);
    bit p, all_a, any_o, r1, r2, r3;
    p     = (($countones(pg) % 2) == 1) != pi;
    all_a = ($countones(a) == AW);
    any_o = ($countones(o) != 0);
    r2 = !all_a || p;
    r3 = p && !any_o;
    r1 = (!p || any_o) && r2;
    return {r1, r2, r3};
  endfunction

  typedef struct {
    logic [2:0] y;
    int         t;
  } item_t;

  item_t q[$];
  int    cyc   = 0;
  int    cnt_m = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      cnt_m = 0;
    end else begin
      item_t it;
      logic  popped_y3;
      cyc++;
      popped_y3 = 1'b0;
      if (out_valid && out_ready && q.size() > 0) begin
        popped_y3 = q[0].y[0];
        void'(q.pop_front());
      end
      if (hit_clr) cnt_m = 0;
      else if (popped_y3 && cnt_m < CMAX) cnt_m++;
      if (in_valid && in_ready) begin
        it.y = ref_y(and_grp, or_grp, par_grp, pi_eff);
        it.t = cyc;
        q.push_back(it);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_hit_cnt", hit_cnt, 0);
      check("rst_y", {y1, y2, y3}, 0);
    end else begin
      logic exp_ov;
      exp_ov = (q.size() > 0) && (cyc >= q[0].t + 1);
      check("m_out_valid", out_valid, exp_ov);
      check("m_in_ready", in_ready, (q.size() < 2) || out_ready);
      check("m_hit_cnt", hit_cnt, cnt_m);
      if (out_valid && q.size() > 0) check("m_y", {y1, y2, y3}, q[0].y);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] a, input logic [1:0] o, input logic [1:0] p, input logic pi);
    int k;
    and_grp = a; or_grp = o; par_grp = p; par_inv = pi; in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 100);
    if (!in_ready) check("send_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; and_grp = '0; or_grp = '0; par_grp = '0;
    par_inv = 1'b0; out_ready = 1'b1; hit_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_hit_cnt", hit_cnt, 0);
    check("reset_in_ready", in_ready, 1);

    // 1: single transaction, latency 2, y3 hit counted on delivery
    send(2'b11, 2'b00, 2'b01, 1'b0);
    @(negedge clk); check("t1_not_yet", out_valid, 0);
    @(negedge clk); check("t1_valid", out_valid, 1);
    check("t1_y", {y1, y2, y3}, 3'b011);
    @(negedge clk); check("t1_hit_cnt", hit_cnt, 1);

    // 2: back-to-back, consecutive in-order delivery
    @(posedge clk); #1;
    and_grp = 2'b11; or_grp = 2'b00; par_grp = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    and_grp = 2'b01; or_grp = 2'b10; par_grp = 2'b11;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); check("t2_a_valid", out_valid, 1); check("t2_a_y", {y1, y2, y3}, 3'b000);
    @(negedge clk); check("t2_b_valid", out_valid, 1); check("t2_b_y", {y1, y2, y3}, 3'b110);

    // 3: stall with out_ready=0, then release
    @(posedge clk); #1 out_ready = 1'b0;
    send(2'b11, 2'b00, 2'b01, 1'b0);
    send(2'b11, 2'b00, 2'b00, 1'b0);
    @(negedge clk); check("t3_in_ready_low", in_ready, 0);
    check("t3_hold_y", {y1, y2, y3}, 3'b011);
    @(negedge clk); check("t3_hold_y2", {y1, y2, y3}, 3'b011);
    #1;
    fork
      begin
        @(posedge clk); #1;
        send(2'b01, 2'b10, 2'b11, 1'b0);
        send(2'b00, 2'b00, 2'b10, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1 check("t3_drained", q.size(), 0);

    // 4: saturation at 2^CW-1, clear wins over a simultaneous hit
    hit_clr = 1'b1;
    @(posedge clk); #1 hit_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(2'b11, 2'b00, 2'b10, 1'b0);
      @(negedge clk); @(negedge clk);
      check("t4_valid", out_valid, 1);
      @(negedge clk);
      check("t4_hit_cnt", hit_cnt, (i + 1 > 3) ? 3 : i + 1);
      @(posedge clk); #1;
    end
    send(2'b11, 2'b00, 2'b10, 1'b0);
    @(negedge clk); @(negedge clk);
    hit_clr = 1'b1;
    @(posedge clk); #1 hit_clr = 1'b0;
    @(negedge clk); check("t4_clr_wins", hit_cnt, 0);

    // 5: asynchronous reset with both stages full
    @(posedge clk); #1;
    send(2'b11, 2'b00, 2'b01, 1'b0);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    send(2'b11, 2'b00, 2'b01, 1'b0);
    send(2'b01, 2'b10, 2'b11, 1'b0);
    @(negedge clk); check("t5_full", in_ready, 0);
    check("t5_pre_hit", hit_cnt, 1);
    #2 rst = 1'b1;
    #1 check("t5_ov_now", out_valid, 0);
    check("t5_cnt_now", hit_cnt, 0);
    check("t5_ready_now", in_ready, 1);
    @(negedge clk); #2 rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    send(2'b01, 2'b10, 2'b11, 1'b0);
    @(negedge clk); check("t5_not_yet", out_valid, 0);
    @(negedge clk); check("t5_valid", out_valid, 1);
    check("t5_y", {y1, y2, y3}, 3'b110);

`ifdef CASE6_PAR_INV_EN
    // 6: inverted parity
    @(posedge clk); #1;
    send(2'b11, 2'b00, 2'b01, 1'b1);
    @(negedge clk); @(negedge clk);
    check("t6_valid", out_valid, 1);
    check("t6_y", {y1, y2, y3}, 3'b000);
`endif

    // Randomised traffic with occasional clears and asynchronous resets
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      and_grp   = AW'($urandom);
      or_grp    = OW'($urandom);
      par_grp   = PW'($urandom);
`ifdef CASE6_PAR_INV_EN
      par_inv   = $urandom_range(0, 1) == 1;
`endif
      out_ready = ($urandom_range(0, 9) < 6);
      hit_clr   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #3 rst = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; hit_clr = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("final_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
